simple_alu_feeder: RTL and testbench

SIMPLE_ALU_FEEDER -- requirements
Module: simple_alu_feeder

---
 rtl/simple_alu_feeder.sv | 236 +++++++++++++++++++++++
 tb/tb_simple_alu_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_alu_feeder.sv
// simple_alu_feeder
//   Streams two operand vectors (A and B) from memory into two small FIFOs
//   that feed an ALU. A start pulse latches the two base addresses and a
//   beat count. The block then issues alternating A/B read requests and
//   steers the in-order responses into the matching FIFO. It raises
//   done_o once everything has been fetched and consumed.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i, base_a_i, base_b_i,
//   len_i                         transfer command (sampled in IDLE)
//   busy_o, done_o                status / one-cycle completion pulse
//   mem_req_o, mem_addr_o,
//   mem_gnt_i                     read request channel (valid/grant)
//   mem_rvalid_i, mem_rdata_i     in-order read response channel
//   a_o, a_valid_o, a_ready_i     operand A stream
//   b_o, b_valid_o, b_ready_i     operand B stream

// Small FIFO; a push into a full FIFO is accepted when a pop happens in
// the same cycle. The head reads as zero while the FIFO is empty.
module simple_alu_feeder_fifo #(
  parameter int Width = 256,
  parameter int Depth = 2,
  parameter int CW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != DEPTH_C) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= inc(wptr_q);
      if (do_pop)  rptr_q <= inc(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = cnt_q;
endmodule

module simple_alu_feeder #(
  parameter int SpatPar   = 4,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 32,
  parameter int FifoDepth = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [AddrWidth-1:0]           base_a_i,
  input  logic [AddrWidth-1:0]           base_b_i,
  input  logic [15:0]                    len_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           mem_req_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [SpatPar*DataWidth-1:0]   mem_rdata_i,
  output logic [SpatPar*DataWidth-1:0]   a_o,
  output logic                           a_valid_o,
  input  logic                           a_ready_i,
  output logic [SpatPar*DataWidth-1:0]   b_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i
);
  localparam int BW = SpatPar * DataWidth;
  localparam int CW = $clog2(FifoDepth + 1);
  localparam logic [AddrWidth-1:0] BEAT_BYTES = AddrWidth'(BW / 8);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [16:0]          tot_q, tot_d;    // 2*len grants per transfer
  logic [16:0]          gcnt_q, gcnt_d;  // grants issued so far
  logic                 tag_q, tag_d;    // port of next response: 0=A, 1=B
  logic [CW-1:0]        out_a_q, out_a_d, out_b_q, out_b_d;
  logic                 done_q, done_d;

  logic [CW-1:0]        cnt_a, cnt_b;
  logic                 sel_b, credit_a, credit_b, req, gnt, rsp;
  logic                 gnt_a, gnt_b, push_a, push_b;

  // The grant count's LSB is the alternation point: even -> A, odd -> B.
  assign sel_b    = gcnt_q[0];
  // Credit is counted against FIFO occupancy plus in-flight reads, so a
  // response always finds room in its FIFO.
  assign credit_a = ({1'b0, cnt_a} + {1'b0, out_a_q}) < DEPTH_C;
  assign credit_b = ({1'b0, cnt_b} + {1'b0, out_b_q}) < DEPTH_C;
  // Credit can only grow while a request waits (pops free space, a
  // response moves an entry from outstanding to FIFO). A raised request
  // therefore stays up until it is granted.
  assign req      = (state_q == FETCH) && (sel_b ? credit_b : credit_a);
  assign gnt      = req && mem_gnt_i;
  assign gnt_a    = gnt && !sel_b;
  assign gnt_b    = gnt && sel_b;
  assign rsp      = mem_rvalid_i && (state_q != IDLE);
  assign push_a   = rsp && !tag_q;
  assign push_b   = rsp && tag_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tot_q    <= '0;
      gcnt_q   <= '0;
      tag_q    <= 1'b0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tot_q    <= tot_d;
      gcnt_q   <= gcnt_d;
      tag_q    <= tag_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tot_d    = tot_q;
    gcnt_d   = gcnt_q;
    tag_d    = rsp ? ~tag_q : tag_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != 16'd0) begin
            addr_a_d = base_a_i;
            addr_b_d = base_b_i;
            tot_d    = {len_i, 1'b0};
            gcnt_d   = '0;
            tag_d    = 1'b0;
            state_d  = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (gnt) begin
          gcnt_d = gcnt_q + 17'd1;
          if (sel_b) addr_b_d = addr_b_q + BEAT_BYTES;
          else       addr_a_d = addr_a_q + BEAT_BYTES;
          if (gcnt_q + 17'd1 == tot_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!a_valid_o && !b_valid_o && out_a_q == '0 && out_b_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A grant and a response on the same port cancel out.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (gnt_a && !push_a)      out_a_d = out_a_q + CW'(1);
    else if (push_a && !gnt_a) out_a_d = out_a_q - CW'(1);
    if (gnt_b && !push_b)      out_b_d = out_b_q + CW'(1);
    else if (push_b && !gnt_b) out_b_d = out_b_q - CW'(1);
  end

  simple_alu_feeder_fifo #(.Width(BW), .Depth(FifoDepth), .CW(CW)) u_fifo_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_a),
    .data_i  (mem_rdata_i),
    .pop_i   (a_ready_i),
    .data_o  (a_o),
    .valid_o (a_valid_o),
    .count_o (cnt_a)
  );

  simple_alu_feeder_fifo #(.Width(BW), .Depth(FifoDepth), .CW(CW)) u_fifo_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_b),
    .data_i  (mem_rdata_i),
    .pop_i   (b_ready_i),
    .data_o  (b_o),
    .valid_o (b_valid_o),
    .count_o (cnt_b)
  );

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign mem_req_o  = req;
  assign mem_addr_o = req ? (sel_b ? addr_b_q : addr_a_q) : '0;
endmodule

// File: tb/tb_simple_alu_feeder.sv
// Randomized bench for simple_alu_feeder with a transaction-level model:
// expected request addresses and expected A/B beat streams are generated
// from the command. The memory returns data derived from the address.
// A negedge monitor compares every handshake and status output.
module tb_simple_alu_feeder;
  localparam int SP = 4, DW = 64, AW = 32, FD = 2, BW = SP * DW;
  localparam int BEAT = BW / 8;

  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [AW-1:0] base_a_i = '0, base_b_i = '0;
  logic [15:0] len_i = '0;
  logic busy_o, done_o, mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_rdata_i = '0, a_o, b_o;
  logic a_valid_o, b_valid_o, a_ready_i = 1'b0, b_ready_i = 1'b0;

  always #5 clk = ~clk;

  simple_alu_feeder #(.SpatPar(SP), .DataWidth(DW), .AddrWidth(AW), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_a_i(base_a_i),
    .base_b_i(base_b_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .a_o(a_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
    .b_o(b_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i));

  int npass = 0, ntot = 0;

  task automatic chk(input bit ok, input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [BW-1:0] dat(input logic [31:0] a);
    logic [BW-1:0] d;
    for (int l = 0; l < SP; l++) d[l*DW +: DW] = {a ^ 32'hA5A5_0F0F, a + 32'(l) * 32'h0101_0101};
    return d;
  endfunction

  typedef struct packed { logic side; logic [31:0] addr; } req_t;
  req_t          exp_req[$];
  logic [31:0]   pend[$];
  logic [BW-1:0] exp_a[$], exp_b[$];
  logic [31:0]   glog[$];
  bit  active = 0, fin_set = 0, chk_rst = 0, req_seen = 0, noise = 0;
  int  cyc = 0, done_cyc = -100, done_seen = 0, ga = 0, gb = 0, pa = 0, pb = 0;
  int  gnt_pct = 100, rv_pct = 100, ra_pct = 100, rb_pct = 100;
  bit  p_req = 0, p_gnt = 0, p_av = 0, p_ar = 0, p_bv = 0, p_br = 0;
  logic [31:0]   p_addr = '0;
  logic [BW-1:0] p_a = '0, p_b = '0;

  // Memory and consumer: random grant/ready; in-order responses.
  always @(posedge clk) begin
    #1;
    mem_gnt_i = (int'($urandom_range(99)) < gnt_pct);
    a_ready_i = (int'($urandom_range(99)) < ra_pct);
    b_ready_i = (int'($urandom_range(99)) < rb_pct);
    if (pend.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = dat(pend[0]);
    end else if (noise && !active) begin
      mem_rvalid_i = 1'($urandom_range(1));
      mem_rdata_i  = {8{$urandom()}};
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  end

  // Monitor / compare against the model.
  always @(negedge clk) begin
    bit popd;
    cyc++;
    if (!rst_ni) begin
      exp_req.delete(); pend.delete(); exp_a.delete(); exp_b.delete();
      active = 0; done_cyc = -100; chk_rst = 1; p_req = 0; p_av = 0; p_bv = 0;
    end else begin
      if (chk_rst) begin
        chk({busy_o, done_o, mem_req_o, a_valid_o, b_valid_o} == 5'b0, "rst_ctl",
            {busy_o, done_o, mem_req_o, a_valid_o, b_valid_o}, 0);
        chk(mem_addr_o == '0, "rst_addr", mem_addr_o, 0);
        chk(a_o == '0, "rst_a", a_o, 0);
        chk(b_o == '0, "rst_b", b_o, 0);
        chk_rst = 0;
      end
      if (cyc == done_cyc) active = 0;
      chk(done_o == (cyc == done_cyc), "done", done_o, cyc == done_cyc);
      if (done_o) done_seen++;
      chk(busy_o == active, "busy", busy_o, active);
      if (p_req && !p_gnt)
        chk(mem_req_o && mem_addr_o == p_addr, "req_hold", {mem_req_o, mem_addr_o}, {1'b1, p_addr});
      if (p_av && !p_ar) chk(a_valid_o && a_o == p_a, "a_hold", a_o, p_a);
      if (p_bv && !p_br) chk(b_valid_o && b_o == p_b, "b_hold", b_o, p_b);
      if (mem_req_o) begin
        req_seen = 1;
        chk(active, "req_active", active, 1);
      end
      if (mem_req_o && mem_gnt_i) begin
        chk(exp_req.size() > 0, "gnt_extra", mem_addr_o, 0);
        if (exp_req.size() > 0) begin
          chk(mem_addr_o == exp_req[0].addr, "gnt_addr", mem_addr_o, exp_req[0].addr);
          if (!exp_req[0].side) begin chk(ga - pa < FD, "credit_a", ga - pa, FD - 1); ga++; end
          else                  begin chk(gb - pb < FD, "credit_b", gb - pb, FD - 1); gb++; end
          exp_req.pop_front();
        end
        glog.push_back(mem_addr_o);
        pend.push_back(mem_addr_o);
      end
      if (mem_rvalid_i && pend.size() > 0) pend.pop_front();
      popd = 0;
      if (a_valid_o && a_ready_i) begin
        chk(exp_a.size() > 0, "a_extra", a_o, 0);
        if (exp_a.size() > 0) begin chk(a_o == exp_a[0], "a_data", a_o, exp_a[0]); exp_a.pop_front(); end
        pa++; popd = 1;
      end
      if (b_valid_o && b_ready_i) begin
        chk(exp_b.size() > 0, "b_extra", b_o, 0);
        if (exp_b.size() > 0) begin chk(b_o == exp_b[0], "b_data", b_o, exp_b[0]); exp_b.pop_front(); end
        pb++; popd = 1;
      end
      // Last beat consumed -> one cycle to see empty, one to register done.
      if (popd && active && !fin_set && exp_req.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0) begin
        fin_set = 1; done_cyc = cyc + 2;
      end
      if (start_i && !active) begin
        if (len_i == 16'd0) done_cyc = cyc + 1;
        else begin
          active = 1; fin_set = 0; ga = 0; gb = 0; pa = 0; pb = 0;
          for (int k = 0; k < int'(len_i); k++) begin
            exp_req.push_back({1'b0, base_a_i + 32'(k * BEAT)});
            exp_req.push_back({1'b1, base_b_i + 32'(k * BEAT)});
            exp_a.push_back(dat(base_a_i + 32'(k * BEAT)));
            exp_b.push_back(dat(base_b_i + 32'(k * BEAT)));
          end
        end
      end
      p_req = mem_req_o; p_gnt = mem_gnt_i; p_addr = mem_addr_o;
      p_av = a_valid_o; p_ar = a_ready_i; p_a = a_o;
      p_bv = b_valid_o; p_br = b_ready_i; p_b = b_o;
    end
  end

  task automatic start_xfer(input logic [31:0] ba, input logic [31:0] bb, input int n);
    @(posedge clk); #1;
    base_a_i = ba; base_b_i = bb; len_i = 16'(n); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0 = done_seen;
    for (int i = 0; i < budget && done_seen == d0; i++) begin @(negedge clk); #1; end
    chk(done_seen > d0, nm, done_seen - d0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got %0d cycles expected finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] lit [6];
    int d0;
    lit[0] = 32'h100; lit[1] = 32'h200; lit[2] = 32'h120;
    lit[3] = 32'h220; lit[4] = 32'h140; lit[5] = 32'h240;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Basic transfer, always ready / always granted.
    glog.delete(); d0 = done_seen;
    start_xfer(32'h100, 32'h200, 3);
    wait_done(200, "s1_done");
    repeat (3) begin @(negedge clk); #1; end
    chk(done_seen - d0 == 1, "s1_done_cnt", done_seen - d0, 1);
    chk(glog.size() == 6, "s1_gnt_cnt", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk(glog[i] == lit[i], "s1_addr", glog[i], lit[i]);

    // Zero-length start.
    req_seen = 0;
    start_xfer(32'h500, 32'h600, 0);
    @(negedge clk); #1;
    chk(done_o == 1'b1, "len0_done", done_o, 1);
    chk(busy_o == 1'b0, "len0_busy", busy_o, 0);
    @(negedge clk); #1;
    chk(done_o == 1'b0, "len0_done_off", done_o, 0);
    chk(req_seen == 0, "len0_noreq", req_seen, 0);

    // A consumer stalled: credit limits A to FD beats in flight.
    ra_pct = 0;
    start_xfer(32'h1000, 32'h2000, 8);
    repeat (40) begin @(negedge clk); #1; end
    chk(ga == 2, "stall_a_gnts", ga, 2);
    chk(gb == 2, "stall_b_gnts", gb, 2);
    chk(mem_req_o == 1'b0, "stall_noreq", mem_req_o, 0);
    ra_pct = 100;
    wait_done(500, "stall_done");

    // Grant withheld on the first request.
    gnt_pct = 0; glog.delete();
    start_xfer(32'h100, 32'h200, 2);
    for (int i = 0; i < 20 && !mem_req_o; i++) begin @(negedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk(mem_req_o && mem_addr_o == 32'h100, "gnt_wait_addr", mem_addr_o, 32'h100);
      @(negedge clk); #1;
    end
    gnt_pct = 100;
    wait_done(200, "gnt_wait_done");
    chk(glog.size() == 4 && glog[0] == 32'h100 && glog[1] == 32'h200 && glog[2] == 32'h120,
        "gnt_wait_seq", glog.size() > 2 ? glog[2] : 0, 32'h120);

    // Reset in the middle of FETCH, then a clean restart.
    rv_pct = 60;
    start_xfer(32'h300, 32'h400, 6);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    chk(busy_o == 1'b0 && done_o == 1'b0, "rst_mid_idle", {busy_o, done_o}, 0);
    glog.delete();
    start_xfer(32'h300, 32'h400, 4);
    wait_done(300, "rst_restart_done");
    chk(glog.size() > 0 && glog[0] == 32'h300, "rst_restart_first", glog.size() > 0 ? glog[0] : 0, 32'h300);

    // Idle response noise must be ignored.
    noise = 1;
    repeat (10) begin @(negedge clk); #1; end
    chk(a_valid_o == 1'b0 && b_valid_o == 1'b0, "idle_noise", {a_valid_o, b_valid_o}, 0);

    // Random transfers, including address wrap and full-FIFO push/pop.
    for (int t = 0; t < 25; t++) begin
      logic [31:0] ba, bb;
      gnt_pct = int'($urandom_range(30, 100));
      rv_pct  = int'($urandom_range(30, 100));
      ra_pct  = int'($urandom_range(10, 100));
      rb_pct  = int'($urandom_range(10, 100));
      ba = (t % 4 == 0) ? 32'hFFFF_FF80 : ($urandom() & 32'hFFFF_FFE0);
      bb = $urandom() & 32'hFFFF_FFE0;
      start_xfer(ba, bb, int'($urandom_range(1, 12)));
      wait_done(3000, "rand_done");
    end

    repeat (5) begin @(negedge clk); #1; end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
